coef_rd_seq: RTL

COEF_RD_SEQ -- requirements
Module: coef_rd_seq

---
 rtl/kyber_ntt_pkg.sv | 22 ++
 rtl/ntt_idx_gen.sv | 35 +++
 rtl/coef_rd_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/kyber_ntt_pkg.sv
// Shared definitions for the Kyber NTT coefficient read path.
//   N          : coefficients per polynomial
//   ADDR_W     : word address width of one coefficient bank (N/4 words)
//   NUM_BANKS  : coefficient banks, interleaved on idx[1:0]
//   NUM_LAYERS : NTT layers per transform (0..6)
//   IDX_W      : width of a coefficient index
//   seq_state_e: read-sequencer FSM states
package kyber_ntt_pkg;

    localparam int N          = 256;
    localparam int ADDR_W     = 6;
    localparam int NUM_BANKS  = 4;
    localparam int NUM_LAYERS = 7;
    localparam int IDX_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } seq_state_e;

endpackage

// File: rtl/ntt_idx_gen.sv
// Combinational butterfly index generator for one NTT layer.
// Ports:
//   k     in  8 : position in the layer's read sequence (0..255)
//   layer in  3 : NTT layer, 0..6 (butterfly span len = 128 >> layer)
//   idx   out 8 : coefficient index to read at position k
// Consecutive k pairs form one butterfly: even k reads the lower operand j,
// odd k reads its partner j + len.
module ntt_idx_gen
    import kyber_ntt_pkg::*;
(
    input  logic [IDX_W-1:0] k,
    input  logic [2:0]       layer,
    output logic [IDX_W-1:0] idx
);

    logic [2:0]       span_log;   // log2(len)
    logic [3:0]       grp_shift;  // log2(len) + 1, one bit wider so 7+1 cannot wrap
    logic [IDX_W-1:0] len;
    logic [IDX_W-1:0] bfly;       // butterfly number b = k >> 1
    logic [IDX_W-1:0] grp_base;
    logic [IDX_W-1:0] grp_off;

    always_comb begin
        span_log  = 3'd7 - layer;
        grp_shift = {1'b0, span_log} + 4'd1;
        len       = IDX_W'(1) << span_log;
        bfly      = {1'b0, k[IDX_W-1:1]};
        // Butterfly groups are 2*len wide; within a group the lower operands
        // occupy the first len slots.
        grp_base  = (bfly >> span_log) << grp_shift;
        grp_off   = bfly & (len - IDX_W'(1));
        idx       = (grp_base | grp_off) + (k[0] ? len : '0);
    end

endmodule

// File: rtl/coef_rd_seq.sv
// Coefficient read sequencer for one NTT layer.
// Walks the 256 butterfly operand indices of the requested layer, issuing one
// read per ready cycle to four interleaved coefficient banks, and steers the
// registered 4:1 bank mux with a matching delayed select.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_i, layer_i    : one-cycle layer request and its layer number (0..6)
//   ready_i             : downstream can accept reads; low stalls issue
//   rd_en_o, rd_addr_o  : bank read strobe and word address (idx[7:2])
//   sel_o               : bank select for the mux, aligned with bank read data
//   valid_o             : mux output holds a sequenced coefficient
//   busy_o, done_o      : layer active, layer-complete pulse
//   err_o               : pulse on a request for layer 7
module coef_rd_seq #(
    parameter int N      = kyber_ntt_pkg::N,
    parameter int ADDR_W = kyber_ntt_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        layer_i,
    input  logic              ready_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [1:0]        sel_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int         K_W       = $clog2(N);
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);
    localparam logic [2:0] MAX_LAYER = 3'(kyber_ntt_pkg::NUM_LAYERS - 1);

    kyber_ntt_pkg::seq_state_e state;

    logic [K_W-1:0] k;
    logic [2:0]     layer_q;
    logic [K_W-1:0] idx;
    logic [1:0]     sel_issue;  // bank of the read issued this cycle
    logic           vld_d1;     // read data present at the mux input

    ntt_idx_gen u_idx_gen (
        .k     (k),
        .layer (layer_q),
        .idx   (idx)
    );

    // NOTE: every register here is a flop updated with non-blocking
    // assignments, so all right-hand sides see pre-edge values and the
    // pipeline stages shift in lockstep regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= kyber_ntt_pkg::ST_IDLE;
            k         <= '0;
            layer_q   <= '0;
            sel_issue <= '0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            rd_en_o <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;

            case (state)
                kyber_ntt_pkg::ST_IDLE: begin
                    busy_o <= 1'b0;
                    if (start_i) begin
                        if (layer_i <= MAX_LAYER) begin
                            layer_q <= layer_i;
                            k       <= '0;
                            busy_o  <= 1'b1;
                            state   <= kyber_ntt_pkg::ST_RUN;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end

                kyber_ntt_pkg::ST_RUN: begin
                    if (ready_i) begin
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= idx[ADDR_W+1:2];
                        sel_issue <= idx[1:0];
                        k         <= k + K_W'(1);
                        if (k == K_LAST) begin
                            state <= kyber_ntt_pkg::ST_DRAIN;
                        end
                    end
                end

                kyber_ntt_pkg::ST_DRAIN: begin
                    // Only the last read can be behind the mux once the issue
                    // strobe has dropped, so data at the mux input with no
                    // read issuing marks the final coefficient.
                    if (done_o) begin
                        busy_o <= 1'b0;
                        state  <= kyber_ntt_pkg::ST_IDLE;
                    end else if (vld_d1 && !rd_en_o) begin
                        done_o <= 1'b1;
                    end
                end

                default: begin
                    state <= kyber_ntt_pkg::ST_IDLE;
                end
            endcase
        end
    end

    // Bank read latency (1) then mux register (1); select follows the read
    // by one cycle and holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d1  <= 1'b0;
            valid_o <= 1'b0;
            sel_o   <= '0;
        end else begin
            vld_d1  <= rd_en_o;
            valid_o <= vld_d1;
            if (rd_en_o) begin
                sel_o <= sel_issue;
            end
        end
    end

endmodule
